// File: rtl/debug_pkg.sv
// Shared constants, display payload type and hex-to-segment table for debug_display.
package debug_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned AN_W  = 8;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned DIG_W = 3;

   // Segment pattern for '0' and the anode pattern selecting digit 0 (both active-low)
   localparam logic [SEG_W-1:0] SEG_RESET = 7'b1000000;
   localparam logic [AN_W-1:0]  AN_RESET  = 8'b1111_1110;

   // Registered 7-segment drive, segments and anodes updated together
   typedef struct packed {
      logic [SEG_W-1:0] seg;
      logic [AN_W-1:0]  an;
   } disp_t;

   // Active-low segment pattern for one hex nibble, bit 0 = segment a
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
      logic [SEG_W-1:0] pat;
      case (nib)
         4'h0: pat = 7'b1000000;
         4'h1: pat = 7'b1111001;
         4'h2: pat = 7'b0100100;
         4'h3: pat = 7'b0110000;
         4'h4: pat = 7'b0011001;
         4'h5: pat = 7'b0010010;
         4'h6: pat = 7'b0000010;
         4'h7: pat = 7'b1111000;
         4'h8: pat = 7'b0000000;
         4'h9: pat = 7'b0010000;
         4'hA: pat = 7'b0001000;
         4'hB: pat = 7'b0000011;
         4'hC: pat = 7'b1000110;
         4'hD: pat = 7'b0100001;
         4'hE: pat = 7'b0000110;
         default: pat = 7'b0001110;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/debug_display_btn_debounce.sv
// Two-flop synchronizer plus level debouncer; emits one pulse per accepted rising level.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);

   localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // Bring the raw button into the clock domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], raw};
      end
   end

   // Accept a new level only after it has been seen for DEBOUNCE_CYCLES cycles in a row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else if (sync[1] == level) begin
         cnt   <= '0;
         pulse <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt   <= '0;
         level <= sync[1];
         pulse <= sync[1];
      end else begin
         cnt   <= cnt + CNT_W'(1);
         pulse <= 1'b0;
      end
   end

endmodule

// File: rtl/debug_display.sv
// Channel watcher: selects one of NUM_CH values, optionally freezes it, and shows it
// on LEDs and a multiplexed hex 7-segment display.
module debug_display
   import debug_pkg::*;
#(
   parameter int unsigned DATA_W          = 16,
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned SCAN_DIV        = 100_000
) (
   input  logic                     clk_100mhz,
   input  logic                     btn_reset,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic                     btn_next,
   input  logic                     sw_freeze,
   output logic [DATA_W-1:0]        LED,
   output logic [SEL_W-1:0]         ch_sel,
   output logic [SEG_W-1:0]         seg,
   output logic [AN_W-1:0]          an
);

   localparam int unsigned NUM_DIG = (DATA_W + 3) / 4;
   localparam int unsigned PAD_W   = NUM_DIG * 4;
   localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_CH - 1);
   localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIG - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   logic              adv;
   logic              load_pend;
   logic [1:0]        freeze_sync;
   logic [DATA_W-1:0] sel_val;
   logic [DATA_W-1:0] cap;
   logic [PAD_W-1:0]  padded;
   logic [3:0]        nib;
   logic [SCAN_W-1:0] scan_cnt;
   logic [DIG_W-1:0]  digit;
   disp_t             disp_next;
   disp_t             disp_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_next_db (
      .clk   (clk_100mhz),
      .rst_n (btn_reset),
      .raw   (btn_next),
      .pulse (adv)
   );

   // Freeze switch needs synchronizing only; a switch does not bounce in a way that matters here
   always_ff @(posedge clk_100mhz or negedge btn_reset) begin
      if (!btn_reset) begin
         freeze_sync <= 2'b00;
      end else begin
         freeze_sync <= {freeze_sync[0], sw_freeze};
      end
   end

   // Step through channels on each accepted press; remember to reload capture once
   always_ff @(posedge clk_100mhz or negedge btn_reset) begin
      if (!btn_reset) begin
         ch_sel    <= '0;
         load_pend <= 1'b0;
      end else begin
         load_pend <= adv;
         if (adv) begin
            ch_sel <= (ch_sel == SEL_LAST) ? '0 : ch_sel + SEL_W'(1);
         end
      end
   end

   // Mux the selected channel out of the flat input bus
   always_comb begin
      sel_val = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (ch_sel == SEL_W'(k)) begin
            sel_val = ch_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // Track the selected channel unless frozen; a press while frozen takes one fresh snapshot
   always_ff @(posedge clk_100mhz or negedge btn_reset) begin
      if (!btn_reset) begin
         cap <= '0;
      end else if (!freeze_sync[1] || load_pend) begin
         cap <= sel_val;
      end
   end

   assign LED = cap;

   // Digit scan timer and digit index
   always_ff @(posedge clk_100mhz or negedge btn_reset) begin
      if (!btn_reset) begin
         scan_cnt <= '0;
         digit    <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         digit    <= (digit == DIG_LAST) ? '0 : digit + DIG_W'(1);
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   // Pick the nibble for the current digit; the top digit is zero-padded
   always_comb begin
      padded = PAD_W'(cap);
      nib    = 4'h0;
      for (int unsigned d = 0; d < NUM_DIG; d++) begin
         if (digit == DIG_W'(d)) begin
            nib = padded[d*4 +: 4];
         end
      end
      disp_next.seg = hex_to_seg(nib);
      disp_next.an  = ~(AN_W'(1) << digit);
   end

   // Segments and anodes share one register so they switch on the same edge
   always_ff @(posedge clk_100mhz or negedge btn_reset) begin
      if (!btn_reset) begin
         disp_q.seg <= SEG_RESET;
         disp_q.an  <= AN_RESET;
      end else begin
         disp_q <= disp_next;
      end
   end

   assign seg = disp_q.seg;
   assign an  = disp_q.an;

endmodule

// File: tb/tb_debug_display.sv
// Directed bench for debug_display: a 16-bit/4-channel instance and a 12-bit/4-channel instance.
module tb_debug_display;

   localparam int unsigned W16 = 16;
   localparam int unsigned W12 = 12;
   localparam int unsigned NCH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst16 = 1'b1;
   logic [NCH*W16-1:0]   data16 = '0;
   logic                 btn16 = 1'b0;
   logic                 frz16 = 1'b0;
   logic [W16-1:0]       led16;
   logic [2:0]           sel16;
   logic [6:0]           seg16;
   logic [7:0]           an16;

   logic                 rst12 = 1'b1;
   logic [NCH*W12-1:0]   data12 = '0;
   logic                 btn12 = 1'b0;
   logic                 frz12 = 1'b0;
   logic [W12-1:0]       led12;
   logic [2:0]           sel12;
   logic [6:0]           seg12;
   logic [7:0]           an12;

   int n_cmp = 0;
   int n_bad = 0;

   debug_display #(
      .DATA_W (W16), .NUM_CH (NCH), .DEBOUNCE_CYCLES (4), .SCAN_DIV (3)
   ) dut16 (
      .clk_100mhz (clk), .btn_reset (rst16), .ch_data (data16),
      .btn_next (btn16), .sw_freeze (frz16),
      .LED (led16), .ch_sel (sel16), .seg (seg16), .an (an16)
   );

   debug_display #(
      .DATA_W (W12), .NUM_CH (NCH), .DEBOUNCE_CYCLES (4), .SCAN_DIV (3)
   ) dut12 (
      .clk_100mhz (clk), .btn_reset (rst12), .ch_data (data12),
      .btn_next (btn12), .sw_freeze (frz12),
      .LED (led12), .ch_sel (sel12), .seg (seg12), .an (an12)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press16();
      btn16 = 1'b1;
      tick(12);
      btn16 = 1'b0;
      tick(12);
   endtask

   task automatic test_reset();
      data16 = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
      data12 = {12'h444, 12'h333, 12'h222, 12'h5A7};
      tick(1);
      rst16 = 1'b0;
      rst12 = 1'b0;
      tick(3);
      n_cmp++; if (led16 !== 16'h0000) begin n_bad++; $display("FAIL reset_led got=%h want=0000", led16); end
      n_cmp++; if (sel16 !== 3'd0) begin n_bad++; $display("FAIL reset_sel got=%0d want=0", sel16); end
      n_cmp++; if (seg16 !== 7'b1000000) begin n_bad++; $display("FAIL reset_seg got=%b want=1000000", seg16); end
      n_cmp++; if (an16 !== 8'hFE) begin n_bad++; $display("FAIL reset_an got=%h want=fe", an16); end
      rst16 = 1'b1;
      rst12 = 1'b1;
      tick(1);
      n_cmp++; if (led16 !== 16'hAAAA) begin n_bad++; $display("FAIL release_led got=%h want=aaaa", led16); end
      n_cmp++; if (sel16 !== 3'd0) begin n_bad++; $display("FAIL release_sel got=%0d want=0", sel16); end
      n_cmp++; if (led12 !== 12'h5A7) begin n_bad++; $display("FAIL release_led12 got=%h want=5a7", led12); end
   endtask

   task automatic test_clean_presses();
      logic [2:0]  sel_exp [4];
      logic [15:0] led_exp [4];
      sel_exp = '{3'd1, 3'd2, 3'd3, 3'd0};
      led_exp = '{16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hAAAA};
      for (int i = 0; i < 4; i++) begin
         press16();
         n_cmp++; if (sel16 !== sel_exp[i]) begin n_bad++; $display("FAIL press%0d_sel got=%0d want=%0d", i, sel16, sel_exp[i]); end
         n_cmp++; if (led16 !== led_exp[i]) begin n_bad++; $display("FAIL press%0d_led got=%h want=%h", i, led16, led_exp[i]); end
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 5; i++) begin
         btn16 = 1'b1;
         tick(2);
         btn16 = 1'b0;
         tick(2);
      end
      n_cmp++; if (sel16 !== 3'd0) begin n_bad++; $display("FAIL bounce_no_adv got=%0d want=0", sel16); end
      btn16 = 1'b1;
      tick(20);
      n_cmp++; if (sel16 !== 3'd1) begin n_bad++; $display("FAIL bounce_held got=%0d want=1", sel16); end
      btn16 = 1'b0;
      tick(12);
      n_cmp++; if (sel16 !== 3'd1) begin n_bad++; $display("FAIL bounce_release got=%0d want=1", sel16); end
      n_cmp++; if (led16 !== 16'hBBBB) begin n_bad++; $display("FAIL bounce_led got=%h want=bbbb", led16); end
   endtask

   task automatic test_freeze();
      press16();
      press16();
      press16();
      n_cmp++; if (sel16 !== 3'd0) begin n_bad++; $display("FAIL freeze_start_sel got=%0d want=0", sel16); end
      frz16 = 1'b1;
      tick(4);
      data16[15:0] = 16'h1234;
      tick(5);
      n_cmp++; if (led16 !== 16'hAAAA) begin n_bad++; $display("FAIL frozen_led got=%h want=aaaa", led16); end
      press16();
      n_cmp++; if (sel16 !== 3'd1) begin n_bad++; $display("FAIL frozen_press_sel got=%0d want=1", sel16); end
      n_cmp++; if (led16 !== 16'hBBBB) begin n_bad++; $display("FAIL frozen_press_led got=%h want=bbbb", led16); end
      data16[31:16] = 16'h5555;
      tick(5);
      n_cmp++; if (led16 !== 16'hBBBB) begin n_bad++; $display("FAIL frozen_hold_led got=%h want=bbbb", led16); end
      frz16 = 1'b0;
      tick(5);
      n_cmp++; if (led16 !== 16'h5555) begin n_bad++; $display("FAIL unfreeze_led got=%h want=5555", led16); end
   endtask

   task automatic test_scan();
      logic [7:0] an_exp [4];
      logic [6:0] seg_exp [4];
      int         guard;
      an_exp  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
      seg_exp = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
      data16[31:16] = 16'h12AF;
      tick(3);
      guard = 0;
      while (an16 == 8'hFE && guard < 20) begin tick(1); guard++; end
      while (an16 != 8'hFE && guard < 40) begin tick(1); guard++; end
      n_cmp++; if (an16 !== 8'hFE) begin n_bad++; $display("FAIL scan_align timeout an=%h want=fe", an16); end
      for (int d = 0; d < 4; d++) begin
         n_cmp++; if (an16 !== an_exp[d]) begin n_bad++; $display("FAIL scan_an%0d got=%h want=%h", d, an16, an_exp[d]); end
         n_cmp++; if (seg16 !== seg_exp[d]) begin n_bad++; $display("FAIL scan_seg%0d got=%b want=%b", d, seg16, seg_exp[d]); end
         tick(2);
         n_cmp++; if (an16 !== an_exp[d]) begin n_bad++; $display("FAIL scan_hold%0d got=%h want=%h", d, an16, an_exp[d]); end
         tick(1);
      end
      n_cmp++; if (an16 !== 8'hFE) begin n_bad++; $display("FAIL scan_wrap got=%h want=fe", an16); end
   endtask

   task automatic test_reset_mid_debounce();
      int bad;
      int guard;
      btn12 = 1'b1;
      tick(4);
      rst12 = 1'b0;
      #1;
      n_cmp++; if (led12 !== 12'h000) begin n_bad++; $display("FAIL mid_rst_led got=%h want=000", led12); end
      n_cmp++; if (sel12 !== 3'd0) begin n_bad++; $display("FAIL mid_rst_sel got=%0d want=0", sel12); end
      n_cmp++; if (seg12 !== 7'b1000000) begin n_bad++; $display("FAIL mid_rst_seg got=%b want=1000000", seg12); end
      n_cmp++; if (an12 !== 8'hFE) begin n_bad++; $display("FAIL mid_rst_an got=%h want=fe", an12); end
      btn12 = 1'b0;
      tick(3);
      rst12 = 1'b1;
      tick(20);
      n_cmp++; if (sel12 !== 3'd0) begin n_bad++; $display("FAIL mid_rst_no_adv got=%0d want=0", sel12); end
      n_cmp++; if (led12 !== 12'h5A7) begin n_bad++; $display("FAIL mid_rst_led_after got=%h want=5a7", led12); end
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (an12[7:3] !== 5'h1F || $countones(~an12[2:0]) != 1) bad++;
         tick(1);
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL an12_pattern bad_cycles=%0d want=0", bad); end
      guard = 0;
      while (an12 != 8'hFB && guard < 20) begin tick(1); guard++; end
      n_cmp++; if (seg12 !== 7'b0010010 || an12 !== 8'hFB) begin n_bad++; $display("FAIL digit2_12 an=%h seg=%b want fb/0010010", an12, seg12); end
      guard = 0;
      while (an12 != 8'hFE && guard < 20) begin tick(1); guard++; end
      n_cmp++; if (seg12 !== 7'b1111000 || an12 !== 8'hFE) begin n_bad++; $display("FAIL digit0_12 an=%h seg=%b want fe/1111000", an12, seg12); end
   endtask

   initial begin
      test_reset();
      test_clean_presses();
      test_bounce();
      test_freeze();
      test_scan();
      test_reset_mid_debounce();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule

// File: doc/debug_display.md
DEBUG_DISPLAY -- requirements
Module: debug_display

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each watched value (legal 4..32).
REQ-002 SHALL have parameter NUM_CH, default 4, number of watched channels (legal 1..8).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, stable cycles required to accept a button level.
REQ-004 SHALL have parameter SCAN_DIV, default 100_000, clock cycles per 7-segment digit slot.
REQ-005 SHALL have port clk_100mhz  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port btn_reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port ch_data  input  NUM_CH*DATA_W  watched values; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port btn_next  input  1  raw, asynchronous, bouncing channel-advance button.
REQ-009 SHALL have port sw_freeze  input  1  raw, asynchronous freeze switch.
REQ-010 SHALL have port LED  output  DATA_W  displayed value.
REQ-011 SHALL have port ch_sel  output  3  currently selected channel index.
REQ-012 SHALL have port seg  output  7  active-low segments a..g.
REQ-013 SHALL have port an  output  8  active-low digit anodes.

Function
REQ-014 SHALL pass btn_next and sw_freeze through 2-flop synchronizers before any other use.
REQ-015 SHALL debounce synchronized btn_next: accepted level changes only after DEBOUNCE_CYCLES consecutive cycles at the new level; counter clears on any disagreement.
REQ-016 SHALL produce a one-cycle advance pulse on each accepted 0->1 transition of btn_next; a held button produces exactly one pulse.
REQ-017 SHALL increment ch_sel on each advance pulse, wrapping from NUM_CH-1 to 0; with NUM_CH=1, ch_sel stays 0.
REQ-018 SHALL load a capture register from the selected channel every cycle while synchronized sw_freeze is 0.
REQ-019 SHALL hold the capture register while sw_freeze is 1, except that an advance pulse while frozen loads the newly selected channel once, on the cycle after the pulse.
REQ-020 SHALL drive LED directly from the capture register (one-cycle latency from ch_data when unfrozen).
REQ-021 SHALL display the capture register in hex on NUM_DIG = ceil(DATA_W/4) digits, digit 0 = least-significant nibble; the top digit is zero-padded when DATA_W is not a multiple of 4.
REQ-022 SHALL advance the digit index every SCAN_DIV cycles, wrapping from NUM_DIG-1 to 0; exactly one an bit low at a time; an bits >= NUM_DIG always 1.
REQ-023 SHALL register seg and an, so they change together on the same edge.
REQ-024 SHALL encode hex 0-F with standard patterns (0 -> seg=7'b1000000, bit0=a).
REQ-025 SHALL give an advance pulse and a freeze-switch change in the same cycle both effect: ch_sel advances; the capture register loads the new channel.

Reset
REQ-026 SHALL, while btn_reset=0, force: ch_sel=0, capture register and LED=0, digit index=0, scan and debounce counters=0, synchronizers=0, debounced level=0, seg=7'b1000000, an=8'b11111110.
REQ-027 SHALL make reset asserted mid-scan or mid-debounce abandon the operation with no advance pulse generated on release.
REQ-028 SHALL deassert reset without a synchronizer inside this block; release timing is the integrator's responsibility.

Structure
REQ-029 SHALL place the hex-to-segment table and the shared reset/segment constants in package debug_pkg.
REQ-030 SHALL implement synchronizer plus debouncer as sub-module btn_debounce (parameter DEBOUNCE_CYCLES), instantiated once for btn_next; sw_freeze uses the synchronizer only.

Verification
REQ-031 SHALL cover: DATA_W=16, NUM_CH=4, DEBOUNCE_CYCLES=4, ch_data={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}, reset release -> LED=16'hAAAA after 1 cycle, ch_sel=0.
REQ-032 SHALL cover: four clean btn_next presses -> ch_sel 1,2,3,0; LED BBBB, CCCC, DDDD, AAAA.
REQ-033 SHALL cover: btn_next toggling every 2 cycles for 20 cycles, then held high -> exactly one ch_sel increment.
REQ-034 SHALL cover: sw_freeze=1 on ch0, ch0 changed to 16'h1234 -> LED stays AAAA; press btn_next -> LED=BBBB and then holds.
REQ-035 SHALL cover: SCAN_DIV=3, value 16'h12AF -> an cycles FE,FD,FB,F7 every 3 cycles; seg = F, A, 2, 1 patterns; an wraps to FE.
REQ-036 SHALL cover: btn_reset pulsed low mid-debounce with DATA_W=12 -> all outputs at reset values; NUM_DIG=3, an bit 3 never low.
